ps2_host_transmitter: RTL

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_transmitter_pkg.sv | 20 ++
 rtl/ps2_edge_watchdog.sv | 26 ++
 rtl/ps2_host_transmitter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_transmitter_pkg.sv
// Shared PS/2 host-transmit definitions: command codes, frame layout and the
// parity helper used when a byte is captured for transmission.
package ps2_host_transmitter_pkg;

  localparam logic [7:0]  PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0]  PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0]  PS2_CMD_ECHO     = 8'hEE;
  localparam int unsigned PS2_FRAME_LENGTH = 11;

  // Bits shifted out after the start bit: data LSB first, then parity.
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_tx_frame_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_edge_watchdog.sv
// Loadable saturating down-counter; expired_c is high whenever the count is zero.
module ps2_edge_watchdog #(
  parameter int unsigned WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired_c
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired_c = (cnt == '0);

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data
// bits + odd parity + stop, then device ACK, all paced by the device clock.
module ps2_host_transmitter
  import ps2_host_transmitter_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned FIRST_TIMEOUT  = 1500000,
  parameter int unsigned BIT_TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned WD_W = $clog2(FIRST_TIMEOUT + 1);
  // Index of the parity bit within the shifted frame (start and stop excluded).
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_LENGTH - 3);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_WAIT1   = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;
  localparam logic [2:0] S_FINISH  = 3'd7;

  logic [2:0]    state, state_nxt;
  ps2_tx_frame_t sh, sh_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [3:0]    bit_inc_c;
  logic          clk_oe_nxt, data_oe_nxt, busy_nxt, rx_inhibit_nxt;
  logic          done_nxt, ack_err_nxt, timeout_nxt;

  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          fall_c;

  logic            wd_load_c;
  logic [WD_W-1:0] wd_value_c;
  logic            wd_expired_c;

  // Pin synchronisers; idle (released) lines read high so reset raises no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fall_c    = clk_prev & ~clk_sync;
  assign bit_inc_c = bit_cnt + 4'd1;

  ps2_edge_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load       (wd_load_c),
    .load_value (wd_value_c),
    .expired_c  (wd_expired_c)
  );

  // Next state and next registered outputs; outputs always reflect the state entered.
  always_comb begin
    state_nxt   = state;
    sh_nxt      = sh;
    bit_cnt_nxt = bit_cnt;
    clk_oe_nxt  = 1'b0;
    data_oe_nxt = 1'b0;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    ack_err_nxt = ack_err;
    timeout_nxt = timeout;
    wd_load_c   = 1'b0;
    wd_value_c  = WD_W'(BIT_TIMEOUT);

    case (state)
      S_IDLE: begin
        wd_load_c  = 1'b1;
        wd_value_c = WD_W'(INHIBIT_CYCLES);
        if (start) begin
          sh_nxt      = '{parity: odd_parity(tx_data), data: tx_data};
          ack_err_nxt = 1'b0;
          timeout_nxt = 1'b0;
          busy_nxt    = 1'b1;
          clk_oe_nxt  = 1'b1;
          state_nxt   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_nxt = 1'b1;
        if (wd_expired_c) begin
          data_oe_nxt = 1'b1;
          state_nxt   = S_RTS;
        end
      end
      S_RTS: begin
        wd_load_c   = 1'b1;
        wd_value_c  = WD_W'(FIRST_TIMEOUT);
        data_oe_nxt = 1'b1;
        state_nxt   = S_WAIT1;
      end
      S_WAIT1: begin
        data_oe_nxt = 1'b1;
        if (fall_c) begin
          wd_load_c   = 1'b1;
          bit_cnt_nxt = 4'd0;
          data_oe_nxt = ~sh[0];
          state_nxt   = S_SEND;
        end else if (wd_expired_c) begin
          data_oe_nxt = 1'b0;
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = S_FINISH;
        end
      end
      S_SEND: begin
        data_oe_nxt = ~sh[bit_cnt];
        if (fall_c) begin
          wd_load_c = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            data_oe_nxt = 1'b0;
            state_nxt   = S_ACK;
          end else begin
            bit_cnt_nxt = bit_inc_c;
            data_oe_nxt = ~sh[bit_inc_c];
          end
        end else if (wd_expired_c) begin
          data_oe_nxt = 1'b0;
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = S_FINISH;
        end
      end
      S_ACK: begin
        if (fall_c) begin
          wd_load_c   = 1'b1;
          ack_err_nxt = data_sync;
          state_nxt   = S_RELEASE;
        end else if (wd_expired_c) begin
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = S_FINISH;
        end
      end
      S_RELEASE: begin
        if (clk_sync && data_sync) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_FINISH;
        end else if (fall_c) begin
          wd_load_c = 1'b1;
        end else if (wd_expired_c) begin
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = S_FINISH;
        end
      end
      S_FINISH: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase

    rx_inhibit_nxt = busy_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      sh          <= '0;
      bit_cnt     <= 4'd0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      rx_inhibit  <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      sh          <= sh_nxt;
      bit_cnt     <= bit_cnt_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      busy        <= busy_nxt;
      rx_inhibit  <= rx_inhibit_nxt;
      done        <= done_nxt;
      ack_err     <= ack_err_nxt;
      timeout     <= timeout_nxt;
    end
  end

endmodule
